// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Message-level round-robin arbiter sharing one uart_tx (FWFT port).
//            Define UART_TX_ARB_TAG_EN to prefix each message with a tag byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] TAG_BASE = 8'h30
) (
  input  logic                 clk_tx,
  input  logic                 rst_clk_tx,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 char_fifo_empty,
  output logic [7:0]           char_fifo_dout,
  input  logic                 char_fifo_rd_en,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_SRC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
`ifdef UART_TX_ARB_TAG_EN
  localparam logic [1:0] ST_TAG  = 2'd2;
`endif

  logic [1:0]         r_state;
  logic [NUM_SRC-1:0] r_grant;
  logic [IW-1:0]      r_gidx;
  logic [IW-1:0]      r_last_grant;
  logic [7:0]         r_out_data;
  logic               r_out_valid;

  logic               w_load_ok;
  logic               w_accept;
  logic [7:0]         w_sel_data;
  logic               w_sel_last;
  logic [IW-1:0]      w_pick;
  logic               w_found;

  assign w_load_ok  = ~r_out_valid | char_fifo_rd_en;
  assign w_sel_data = src_data[8*r_gidx +: 8];
  assign w_sel_last = src_last[r_gidx];
  assign w_accept   = (r_state == ST_XFER) & w_load_ok & src_valid[r_gidx];

  assign src_ready       = ((r_state == ST_XFER) && w_load_ok) ? r_grant : '0;
  assign char_fifo_empty = ~r_out_valid;
  assign char_fifo_dout  = r_out_data;
  assign grant           = r_grant;
  assign busy            = (r_state != ST_IDLE) | r_out_valid;

`ifndef UART_TX_ARB_TAG_EN
  logic [7:0] w_unused_tag_base;
  assign w_unused_tag_base = TAG_BASE;
`endif

  // First valid source after the previous owner, wrapping modulo NUM_SRC.
  always_comb begin
    w_pick  = r_last_grant;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int v_idx;
      v_idx = (int'(r_last_grant) + k) % NUM_SRC;
      if (!w_found && src_valid[v_idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_last_grant <= IW'(NUM_SRC - 1);
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
    end else begin
      // A pop empties the register unless a load below refills it.
      if (char_fifo_rd_en) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= NUM_SRC'(1) << w_pick;
            r_gidx  <= w_pick;
`ifdef UART_TX_ARB_TAG_EN
            r_state <= ST_TAG;
`else
            r_state <= ST_XFER;
`endif
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        ST_TAG: begin
          if (w_load_ok) begin
            r_out_data  <= TAG_BASE + 8'(r_gidx);
            r_out_valid <= 1'b1;
            r_state     <= ST_XFER;
          end
        end
`endif
        ST_XFER: begin
          if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_valid <= 1'b1;
            if (w_sel_last) begin
              r_last_grant <= r_gidx;
              r_grant      <= '0;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Self-checking bench for uart_tx_arb against a round-robin message model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int         NS   = 4;
  localparam logic [7:0] TAGB = 8'h30;
`ifdef UART_TX_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic            char_fifo_empty;
  logic [7:0]      char_fifo_dout;
  logic            char_fifo_rd_en;
  logic [NS-1:0]   grant;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_SRC(NS), .TAG_BASE(TAGB)) dut (
    .clk_tx          (clk),
    .rst_clk_tx      (rst),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_last        (src_last),
    .src_ready       (src_ready),
    .char_fifo_empty (char_fifo_empty),
    .char_fifo_dout  (char_fifo_dout),
    .char_fifo_rd_en (char_fifo_rd_en),
    .grant           (grant),
    .busy            (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pending traffic per source, and the reference model's outputs.
  logic [7:0] q_data [NS][$];
  bit         q_last [NS][$];
  bit         in_msg [NS];
  int         m_ptr;
  logic [7:0] exp_data [$];
  int         exp_src  [$];
  logic [7:0] got_data [$];
  int         got_cyc  [$];
  int         done_src [$];
  bit         timeout;
  int         bad_grant;
  logic [NS-1:0] grant_or;

  function automatic longint enc_q(input int q[$]);
    longint e = 0;
    foreach (q[k]) e = e * 10 + longint'(q[k] + 1);
    return e;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < NS; i++) begin
      q_data[i].delete();
      q_last[i].delete();
      in_msg[i] = 1'b0;
    end
  endtask

  task automatic add_msg(input int s, input int len);
    for (int k = 0; k < len; k++) begin
      q_data[s].push_back(8'($urandom));
      q_last[s].push_back(k == len - 1);
    end
  endtask

  // Whole messages in round-robin order from the previous owner onward.
  task automatic build_model();
    int pos [NS];
    int s;
    bit fin;
    exp_data.delete();
    exp_src.delete();
    for (int i = 0; i < NS; i++) pos[i] = 0;
    forever begin
      s = -1;
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_ptr + k) % NS;
        if (s < 0 && pos[c] < q_data[c].size()) s = c;
      end
      if (s < 0) break;
      if (TAGN != 0) exp_data.push_back(TAGB + 8'(s));
      fin = 1'b0;
      while (!fin) begin
        exp_data.push_back(q_data[s][pos[s]]);
        fin = q_last[s][pos[s]];
        pos[s]++;
      end
      exp_src.push_back(s);
      m_ptr = s;
    end
  endtask

  // Sources present queued bytes (stalls only mid-message); sink pops per rd_mode.
  task automatic run_traffic(input int rd_mode, input int stall_pct, input int max_cyc);
    bit prev_rd;
    bit done;
    int c;
    got_data.delete();
    got_cyc.delete();
    done_src.delete();
    timeout   = 1'b0;
    bad_grant = 0;
    grant_or  = '0;
    prev_rd   = 1'b0;
    c         = 0;
    forever begin
      @(negedge clk);
      done = !busy && char_fifo_empty;
      for (int i = 0; i < NS; i++) if (q_data[i].size() != 0) done = 1'b0;
      if (done) break;
      if (c >= max_cyc) begin
        timeout = 1'b1;
        break;
      end
      for (int i = 0; i < NS; i++) begin
        if (q_data[i].size() != 0) begin
          src_valid[i]       = in_msg[i] ? ($urandom_range(99) >= stall_pct) : 1'b1;
          src_data[8*i +: 8] = q_data[i][0];
          src_last[i]        = q_last[i][0];
        end else begin
          src_valid[i]       = 1'b0;
          src_data[8*i +: 8] = 8'($urandom);
          src_last[i]        = 1'b0;
        end
      end
      case (rd_mode)
        0:       char_fifo_rd_en = 1'($urandom_range(1));
        1:       char_fifo_rd_en = 1'b1;
        default: char_fifo_rd_en = !char_fifo_empty && !prev_rd;
      endcase
      prev_rd = char_fifo_rd_en;
      #1;
      if ((grant & (grant - 1'b1)) != '0) bad_grant++;
      grant_or |= grant;
      if (!char_fifo_empty && char_fifo_rd_en) begin
        got_data.push_back(char_fifo_dout);
        got_cyc.push_back(c);
      end
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          if (q_last[i][0]) begin
            done_src.push_back(i);
            in_msg[i] = 1'b0;
          end else begin
            in_msg[i] = 1'b1;
          end
          void'(q_data[i].pop_front());
          void'(q_last[i].pop_front());
        end
      end
      c++;
    end
    src_valid       = '0;
    src_last        = '0;
    char_fifo_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_ptr = NS - 1;
    clear_q();
  endtask

  task automatic test_reset();
    logic [8+8+2*NS-1:0] obs;
    logic [8+8+2*NS-1:0] want;
    want = {8'h01, 8'h00, {NS{1'b0}}, {NS{1'b0}}};
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b0;
      #1;
      obs = {7'd0, char_fifo_empty | busy << 1 ? char_fifo_empty : 1'b0, char_fifo_dout, grant, src_ready};
      obs[9] = busy;
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL reset_c%0d: got empty=%b busy=%b dout=%h grant=%b ready=%b want empty=1 busy=0 dout=00 grant=0 ready=0",
                 c, char_fifo_empty, busy, char_fifo_dout, grant, src_ready);
      end
    end
    m_ptr = NS - 1;
  endtask

  task automatic test_single_src();
    int bad;
    clear_q();
    q_data[2].push_back(8'h41); q_last[2].push_back(1'b0);
    q_data[2].push_back(8'h42); q_last[2].push_back(1'b0);
    q_data[2].push_back(8'h43); q_last[2].push_back(1'b1);
    build_model();
    run_traffic(2, 0, 200);
    n_tests++;
    if (timeout || got_data.size() != 3 + TAGN) begin
      n_fail++;
      $display("FAIL single_len: got %0d bytes (timeout=%0d) want %0d", got_data.size(), timeout, 3 + TAGN);
    end
    n_tests++;
    bad = -1;
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
      if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL single_data[%0d]: got %h want %h", bad, got_data[bad], exp_data[bad]);
    end
    n_tests++;
    if (grant_or !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 0100", grant_or);
    end
    n_tests++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got grant=%b busy=%b want 0000 0", grant, busy);
    end
  endtask

  task automatic test_three_src();
    int bad;
    do_reset();
    add_msg(0, 2);
    add_msg(1, 2);
    add_msg(3, 2);
    build_model();
    run_traffic(0, 0, 300);
    n_tests++;
    if (timeout || enc_q(done_src) != 64'd124) begin
      n_fail++;
      $display("FAIL three_order: got %0d (timeout=%0d) want 124", enc_q(done_src), timeout);
    end
    n_tests++;
    bad = (got_data.size() != exp_data.size()) ? 0 : -1;
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
      if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL three_stream: first bad index %0d, got %0d bytes want %0d", bad, got_data.size(), exp_data.size());
    end
  endtask

  task automatic test_alternate();
    int bad;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      add_msg(0, $urandom_range(1, 3));
      add_msg(1, $urandom_range(1, 3));
    end
    build_model();
    run_traffic(0, 0, 500);
    n_tests++;
    if (timeout || enc_q(done_src) != 64'd121212) begin
      n_fail++;
      $display("FAIL alt_order: got %0d (timeout=%0d) want 121212", enc_q(done_src), timeout);
    end
    n_tests++;
    bad = (got_data.size() != exp_data.size()) ? 0 : -1;
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
      if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL alt_stream: first bad index %0d, got %0d bytes want %0d", bad, got_data.size(), exp_data.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_q();
    add_msg(0, 5);
    build_model();
    run_traffic(1, 0, 200);
    n_tests++;
    if (timeout || got_data.size() != 5 + TAGN) begin
      n_fail++;
      $display("FAIL b2b_len: got %0d bytes (timeout=%0d) want %0d", got_data.size(), timeout, 5 + TAGN);
    end else begin
      n_tests++;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != 4 + TAGN) begin
        n_fail++;
        $display("FAIL b2b_span: got %0d cycles want %0d", got_cyc[got_cyc.size()-1] - got_cyc[0], 4 + TAGN);
      end
    end
    n_tests++;
    bad = (got_data.size() != exp_data.size()) ? 0 : -1;
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
      if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL b2b_stream: first bad index %0d", bad);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      char_fifo_rd_en = 1'b1;
      #1;
      n_tests++;
      if (char_fifo_empty !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_underflow_c%0d: got empty=%b busy=%b want 1 0", c, char_fifo_empty, busy);
      end
    end
    @(negedge clk);
    char_fifo_rd_en = 1'b0;
  endtask

`ifndef UART_TX_ARB_TAG_EN
  task automatic test_latency();
    @(negedge clk);
    src_valid        = 4'b0010;
    src_data[15:8]   = 8'h77;
    src_last         = 4'b0010;
    char_fifo_rd_en  = 1'b0;
    #1;
    n_tests++;
    if (src_ready !== 4'b0000 || char_fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_c0: got ready=%b empty=%b want 0000 1", src_ready, char_fifo_empty);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (src_ready !== 4'b0010 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL lat_c1: got ready=%b grant=%b want 0010 0010", src_ready, grant);
    end
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;
    #1;
    n_tests++;
    if (char_fifo_empty !== 1'b0 || char_fifo_dout !== 8'h77 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL lat_c2: got empty=%b dout=%h grant=%b want 0 77 0000", char_fifo_empty, char_fifo_dout, grant);
    end
    @(negedge clk);
    char_fifo_rd_en = 1'b1;
    @(negedge clk);
    char_fifo_rd_en = 1'b0;
    #1;
    n_tests++;
    if (char_fifo_empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_drain: got empty=%b busy=%b want 1 0", char_fifo_empty, busy);
    end
    m_ptr = 1;
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    int bad;
    clear_q();
    @(negedge clk);
    src_valid        = 4'b0100;
    src_data[23:16]  = 8'hA0;
    src_last         = '0;
    char_fifo_rd_en  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (src_ready[2]) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_ready: got no src_ready[2] want ready within 10 cycles");
    end
    @(negedge clk);
    src_data[23:16] = 8'hA1;
    char_fifo_rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (char_fifo_empty !== 1'b1 || grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: got empty=%b grant=%b busy=%b want 1 0000 0", char_fifo_empty, grant, busy);
    end
    rst       = 1'b0;
    src_valid = '0;
    m_ptr     = NS - 1;
    for (int i = 0; i < NS; i++) add_msg(i, 1);
    build_model();
    run_traffic(0, 0, 300);
    n_tests++;
    if (timeout || enc_q(done_src) != 64'd1234) begin
      n_fail++;
      $display("FAIL rstmid_order: got %0d (timeout=%0d) want 1234", enc_q(done_src), timeout);
    end
    n_tests++;
    bad = (got_data.size() != exp_data.size()) ? 0 : -1;
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
      if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL rstmid_stream: first bad index %0d, got %0d bytes want %0d", bad, got_data.size(), exp_data.size());
    end
  endtask

  task automatic test_random();
    int bad;
    for (int r = 0; r < 6; r++) begin
      clear_q();
      for (int i = 0; i < NS; i++) begin
        int nm;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) add_msg(i, $urandom_range(1, 4));
      end
      build_model();
      run_traffic(0, 25, 2000);
      n_tests++;
      if (timeout || enc_q(done_src) != enc_q(exp_src)) begin
        n_fail++;
        $display("FAIL rand%0d_order: got %0d (timeout=%0d) want %0d", r, enc_q(done_src), timeout, enc_q(exp_src));
      end
      n_tests++;
      bad = (got_data.size() != exp_data.size()) ? 0 : -1;
      for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
        if (bad < 0 && got_data[k] !== exp_data[k]) bad = k;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL rand%0d_stream: first bad index %0d, got %0d bytes want %0d", r, bad, got_data.size(), exp_data.size());
      end
      n_tests++;
      if (bad_grant != 0) begin
        n_fail++;
        $display("FAIL rand%0d_onehot: got %0d non-onehot grant cycles want 0", r, bad_grant);
      end
    end
  endtask

`ifdef UART_TX_ARB_TAG_EN
  task automatic test_tag();
    do_reset();
    q_data[3].push_back(8'h5A);
    q_last[3].push_back(1'b1);
    build_model();
    run_traffic(0, 0, 200);
    n_tests++;
    if (timeout || got_data.size() != 2) begin
      n_fail++;
      $display("FAIL tag_len: got %0d bytes (timeout=%0d) want 2", got_data.size(), timeout);
    end else begin
      n_tests++;
      if (got_data[0] !== 8'h33 || got_data[1] !== 8'h5A) begin
        n_fail++;
        $display("FAIL tag_bytes: got %h %h want 33 5a", got_data[0], got_data[1]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    src_valid       = '0;
    src_data        = '0;
    src_last        = '0;
    char_fifo_rd_en = 1'b0;
    m_ptr           = NS - 1;
    clear_q();
    test_reset();
    test_single_src();
    test_three_src();
    test_alternate();
    test_back_to_back();
`ifndef UART_TX_ARB_TAG_EN
    test_latency();
`endif
    test_reset_mid();
    test_random();
`ifdef UART_TX_ARB_TAG_EN
    test_tag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Message-level round-robin arbiter that shares the single UART transmitter among NUM_SRC byte-stream requesters.
- Sits between the requesters and uart_tx.
- Presents the same first-word-fall-through (FWFT) char-FIFO interface that uart_tx consumes: empty / dout / rd_en.
- Once a source is granted, it keeps the transmitter until its byte flagged last is accepted. Messages never interleave.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..8.
- TAG_BASE, 8'h30, base value of the tag byte; used only when UART_TX_ARB_TAG_EN is defined.

Ports:
- clk_tx  in  1  clock; same domain as uart_tx.
- rst_clk_tx  in  1  reset; synchronous to clk_tx, active high.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  8*NUM_SRC  per-source byte; source i uses bits [8*i+7:8*i].
- src_last  in  NUM_SRC  per-source flag: this byte ends the message.
- src_ready  out  NUM_SRC  per-source accept.
- char_fifo_empty  out  1  FWFT empty flag to uart_tx.
- char_fifo_dout  out  8  FWFT data to uart_tx.
- char_fifo_rd_en  in  1  pop from uart_tx.
- grant  out  NUM_SRC  one-hot owner of the transmitter; all zero when idle.
- busy  out  1  high whenever the FSM is not in IDLE or the output register is loaded.

Behaviour:
- Reset values:
  - char_fifo_empty=1, char_fifo_dout=8'h00.
  - src_ready=0, grant=0, busy=0.
  - FSM=IDLE.
  - Round-robin pointer last_grant=NUM_SRC-1, so source 0 has top priority after reset.
- Reset is synchronous and dominates everything. If asserted mid-message, the partial message is dropped and the loaded byte is discarded.
- Output stage: one byte register out_data plus out_valid.
  - char_fifo_empty = ~out_valid; char_fifo_dout = out_data.
  - load_ok = ~out_valid | char_fifo_rd_en. This allows back-to-back bytes with no bubble.
  - char_fifo_rd_en while empty is ignored.
  - char_fifo_rd_en with no new load clears out_valid next cycle.
- Source handshake: a byte is transferred when src_valid[i] & src_ready[i] at a rising edge.
  - src_ready[i] = (state==XFER) & grant[i] & load_ok.
  - src_ready is combinational from rd_en. Sources must not make src_valid depend on src_ready.
- FSM states:
  - IDLE:
    - If any src_valid is set, choose the first valid source scanning last_grant+1 upward with wrap-around (modulo NUM_SRC).
    - Register grant one-hot. Go to TAG if the macro is enabled, else XFER.
    - No byte is accepted in IDLE, so there is 1 cycle of arbitration latency.
  - TAG: present only with the macro; see Optional Feature.
  - XFER:
    - Each accepted byte loads out_data and sets out_valid.
    - On an accepted byte with src_last set: last_grant<=granted index, grant<=0, go to IDLE.
- src_valid deasserting during XFER stalls the transfer. The grant is held indefinitely; there is no timeout.
- Latency: src_valid rising in IDLE with the output register empty gives src_ready at cycle +1 and char_fifo_empty low at cycle +2.
- Boundary cases:
  - A 1-byte message (last on the first byte) is legal.
  - Requests arriving during another owner's message wait; the owner is never preempted.
  - If the owner deasserts src_valid after its last byte and re-requests immediately, it gets the grant again only if no other source is valid.
  - Every valid source is granted within NUM_SRC messages.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined:
  - IDLE goes to TAG.
  - TAG waits for load_ok, then loads TAG_BASE+granted_index into the output register and goes to XFER.
  - src_ready is 0 throughout TAG.
  - Each message is therefore preceded by one ASCII tag byte (default "0".."7").
- Undefined: the TAG state and the adder are absent; IDLE goes straight to XFER.

Test Plan:
- Reset, no requests: empty=1, grant=0, busy=0, src_ready=0 throughout.
- Source 2 sends 3 bytes 8'h41,8'h42,8'h43 with last on the third; rd_en pulses one cycle after each non-empty cycle:
  - dout sequence is 41,42,43 with no extra bytes.
  - grant=4'b0100 during transfer, returns to 0, busy falls.
- Sources 0,1,3 request simultaneously with 2-byte messages:
  - Service order is 0,1,3.
  - No interleaving; each message is contiguous on dout.
- Source 1 holds src_valid continuously while source 0 re-requests after each message: grants alternate 0,1,0,1.
- rd_en held constantly high with the source always valid: one byte per cycle after the first; rd_en while empty causes no underflow.
- Reset asserted mid-message after 1 of 4 bytes:
  - Next cycle empty=1, grant=0.
  - A subsequent request from source 0 is granted first.
- With UART_TX_ARB_TAG_EN defined: a 1-byte message 8'h5A from source 3 yields dout 8'h33 then 8'h5A.
